// File: rtl/dino_pkg.sv
// Shared types and default geometry for the dino runner: jump FSM states and
// the default physics constants used by the renderer and collision logic.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } dino_state_t;

  localparam int unsigned DINO_Y_W     = 8;
  localparam int unsigned DINO_V_W     = 6;
  localparam int unsigned DINO_TICK_DIV = 60000;
  localparam int unsigned DINO_GROUND_Y = 181;
  localparam int unsigned DINO_MIN_Y    = 0;
  localparam int unsigned DINO_JUMP_V   = 10;
  localparam int unsigned DINO_CUT_V    = 3;
  localparam int unsigned DINO_GRAVITY  = 1;
  localparam int unsigned DINO_MAX_FALL = 15;

endpackage

// File: rtl/dino_tick_gen.sv
// Free-running physics tick: one-cycle strobe every TICK_DIV clocks.
module dino_tick_gen #(
  parameter int unsigned TICK_DIV = 60000
) (
  input  logic clk,
  input  logic nRst,
  output logic tick
);

  localparam int unsigned          CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/dino_jump_ctrl.sv
// Jump-physics controller: button/duck in, sprite Y out. Rise with variable
// height cut, ceiling clamp, gravity fall with duck fast-fall, landing strobe.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned Y_W      = DINO_Y_W,
  parameter int unsigned V_W      = DINO_V_W,
  parameter int unsigned TICK_DIV = DINO_TICK_DIV,
  parameter int unsigned GROUND_Y = DINO_GROUND_Y,
  parameter int unsigned MIN_Y    = DINO_MIN_Y,
  parameter int unsigned JUMP_V   = DINO_JUMP_V,
  parameter int unsigned CUT_V    = DINO_CUT_V,
  parameter int unsigned GRAVITY  = DINO_GRAVITY,
  parameter int unsigned MAX_FALL = DINO_MAX_FALL
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           button,
  input  logic           duck,
  output logic [Y_W-1:0] dinoY,
  output logic           airborne,
  output logic           ducking,
  output logic           land_pulse
);

  localparam logic [Y_W-1:0] GROUND_Y_C = Y_W'(GROUND_Y);
  localparam logic [Y_W-1:0] MIN_Y_C    = Y_W'(MIN_Y);
  localparam logic [V_W-1:0] JUMP_V_C   = V_W'(JUMP_V);
  localparam logic [V_W-1:0] CUT_V_C    = V_W'(CUT_V);
  localparam logic [V_W-1:0] GRAVITY_C  = V_W'(GRAVITY);
  localparam logic [V_W-1:0] MAX_FALL_C = V_W'(MAX_FALL);
  localparam logic [V_W:0]   G_NORM     = (V_W+1)'(GRAVITY);
  localparam logic [V_W:0]   G_FAST     = (V_W+1)'(2 * GRAVITY);

  dino_state_t     r_state, w_state_nxt;
  logic [Y_W-1:0]  r_y, w_y_nxt;
  logic [V_W-1:0]  r_vup, w_vup_nxt;
  logic [V_W-1:0]  r_vdn, w_vdn_nxt;
  logic            r_btn_q;
  logic            r_land, w_land_nxt;

  logic            w_tick;
  logic            w_jump_req;
  logic [V_W-1:0]  w_vup_eff;
  logic signed [Y_W:0] w_ny_rise;
  logic            w_ceil_hit;
  logic [Y_W:0]    w_ny_fall;
  logic [V_W:0]    w_vdn_sum;
  logic [V_W-1:0]  w_vdn_sat;

  dino_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .nRst (nRst),
    .tick (w_tick)
  );

  assign w_jump_req = button & ~r_btn_q;

  // Early release caps the rise; a coincident tick already sees the capped value.
  assign w_vup_eff  = (!button && (r_vup > CUT_V_C)) ? CUT_V_C : r_vup;

  assign w_ny_rise  = $signed({1'b0, r_y}) - $signed((Y_W+1)'(w_vup_eff));
  assign w_ceil_hit = w_ny_rise < $signed({1'b0, MIN_Y_C});
  assign w_ny_fall  = {1'b0, r_y} + (Y_W+1)'(r_vdn);
  assign w_vdn_sum  = {1'b0, r_vdn} + (duck ? G_FAST : G_NORM);
  assign w_vdn_sat  = (w_vdn_sum > {1'b0, MAX_FALL_C}) ? MAX_FALL_C : w_vdn_sum[V_W-1:0];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= GROUND;
      r_y     <= GROUND_Y_C;
      r_vup   <= '0;
      r_vdn   <= '0;
      r_btn_q <= 1'b0;
      r_land  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_vup   <= w_vup_nxt;
      r_vdn   <= w_vdn_nxt;
      r_btn_q <= button;
      r_land  <= w_land_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vup_nxt   = r_vup;
    w_vdn_nxt   = r_vdn;
    w_land_nxt  = 1'b0;

    unique case (r_state)
      GROUND: begin
        if (!duck && w_jump_req) begin
          w_state_nxt = RISE;
          w_vup_nxt   = JUMP_V_C;
        end
      end

      RISE: begin
        w_vup_nxt = w_vup_eff;
        if (w_tick) begin
          if (w_ceil_hit) begin
            w_y_nxt     = MIN_Y_C;
            w_state_nxt = FALL;
            w_vup_nxt   = '0;
            w_vdn_nxt   = GRAVITY_C;
          end else begin
            w_y_nxt = w_ny_rise[Y_W-1:0];
            if (w_vup_eff <= GRAVITY_C) begin
              w_state_nxt = FALL;
              w_vup_nxt   = '0;
              w_vdn_nxt   = GRAVITY_C;
            end else begin
              w_vup_nxt = w_vup_eff - GRAVITY_C;
            end
          end
        end
      end

      FALL: begin
        if (w_tick) begin
          if (w_ny_fall >= {1'b0, GROUND_Y_C}) begin
            w_y_nxt     = GROUND_Y_C;
            w_state_nxt = GROUND;
            w_vdn_nxt   = '0;
            w_land_nxt  = 1'b1;
          end else begin
            w_y_nxt   = w_ny_fall[Y_W-1:0];
            w_vdn_nxt = w_vdn_sat;
          end
        end
      end

      default: w_state_nxt = GROUND;
    endcase
  end

  assign dinoY      = r_y;
  assign airborne   = (r_state == RISE) || (r_state == FALL);
  assign ducking    = (r_state == GROUND) && duck;
  assign land_pulse = r_land;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scoreboard bench for dino_jump_ctrl: stimulus pushes expected Y trajectories,
// per-instance monitors pop and compare on every dinoY change.
module tb_dino_jump_ctrl;

  typedef struct packed {
    logic [7:0] y;
    logic       land;
  } exp_t;

  logic       clk;
  logic       nRst;
  logic       button, btn2, duck;
  logic [7:0] dinoY0, dinoY1;
  logic       air0, air1, duck0, duck1, land0, land1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  dino_jump_ctrl #(.TICK_DIV(4)) dut0 (
    .clk(clk), .nRst(nRst), .button(button), .duck(duck),
    .dinoY(dinoY0), .airborne(air0), .ducking(duck0), .land_pulse(land0)
  );

  dino_jump_ctrl #(.TICK_DIV(4), .MIN_Y(130)) dut1 (
    .clk(clk), .nRst(nRst), .button(btn2), .duck(duck),
    .dinoY(dinoY1), .airborne(air1), .ducking(duck1), .land_pulse(land1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seq(input int which, input int ys[$]);
    exp_t e;
    foreach (ys[i]) begin
      e.y    = 8'(ys[i]);
      e.land = (ys[i] == 181);
      if (which == 0) sb0.push_back(e);
      else            sb1.push_back(e);
    end
  endtask

  task automatic wait_y0(input int target, input int budget);
    int n = 0;
    while (dinoY0 != 8'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_dinoY", 32'(dinoY0), 32'(target));
  endtask

  task automatic wait_idle(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? (sb0.size() != 0 || air0) : (sb1.size() != 0 || air1)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'((which == 0) ? sb0.size() : sb1.size()), 32'd0);
    check("drain_airborne", 32'((which == 0) ? air0 : air1), 32'd0);
  endtask

  // Monitor for the default instance
  initial begin
    logic [7:0] prev;
    exp_t       e;
    prev = 8'd181;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        prev = dinoY0;
      end else if (dinoY0 !== prev) begin
        if (sb0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m0_unexpected: got dinoY=%0d, nothing expected", dinoY0);
        end else begin
          e = sb0.pop_front();
          check("m0_dinoY", 32'(dinoY0), 32'(e.y));
          check("m0_land_pulse", 32'(land0), 32'(e.land));
        end
        prev = dinoY0;
      end else begin
        check("m0_land_idle", 32'(land0), 32'd0);
      end
    end
  end

  // Monitor for the low-ceiling instance
  initial begin
    logic [7:0] prev;
    exp_t       e;
    prev = 8'd181;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        prev = dinoY1;
      end else if (dinoY1 !== prev) begin
        if (sb1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m1_unexpected: got dinoY=%0d, nothing expected", dinoY1);
        end else begin
          e = sb1.pop_front();
          check("m1_dinoY", 32'(dinoY1), 32'(e.y));
          check("m1_land_pulse", 32'(land1), 32'(e.land));
        end
        prev = dinoY1;
      end else begin
        check("m1_land_idle", 32'(land1), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int full_seq[$];
    int hop_seq[$];
    int ceil_seq[$];
    int duck_seq[$];

    full_seq = '{171, 162, 154, 147, 141, 136, 132, 129, 127, 126,
                 127, 129, 132, 136, 141, 147, 154, 162, 171, 181};
    hop_seq  = '{171, 162, 159, 157, 156,
                 157, 159, 162, 166, 171, 177, 181};
    ceil_seq = '{171, 162, 154, 147, 141, 136, 132, 130,
                 131, 133, 136, 140, 145, 151, 158, 166, 175, 181};
    duck_seq = '{171, 162, 154, 147, 141, 136, 132, 129, 127, 126,
                 127, 130, 135, 142, 151, 162, 175, 181};

    button = 1'b0;
    btn2   = 1'b0;
    duck   = 1'b0;
    nRst   = 1'b1;
    #1 nRst = 1'b0;
    #2;
    check("rst_dinoY", 32'(dinoY0), 32'd181);
    check("rst_airborne", 32'(air0), 32'd0);
    check("rst_land_pulse", 32'(land0), 32'd0);
    check("rst_ducking", 32'(duck0), 32'd0);
    check("rst_dinoY_ceil", 32'(dinoY1), 32'd181);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);

    // Full jump with button held, then hold through landing
    push_seq(0, full_seq);
    button = 1'b1;
    #1 check("jump_airborne_before_edge", 32'(air0), 32'd0);
    @(negedge clk);
    check("jump_airborne_after_edge", 32'(air0), 32'd1);
    check("jump_dinoY_before_tick", 32'(dinoY0), 32'd181);
    wait_idle(0, 300);
    repeat (30) @(negedge clk);
    check("held_no_rejump_airborne", 32'(air0), 32'd0);
    check("held_no_rejump_dinoY", 32'(dinoY0), 32'd181);
    button = 1'b0;
    repeat (3) @(negedge clk);

    // Short hop: release after the second tick
    push_seq(0, hop_seq);
    button = 1'b1;
    wait_y0(162, 300);
    button = 1'b0;
    wait_idle(0, 300);
    repeat (3) @(negedge clk);

    // Ceiling clamp on the MIN_Y=130 instance
    push_seq(1, ceil_seq);
    btn2 = 1'b1;
    @(negedge clk);
    check("ceil_airborne", 32'(air1), 32'd1);
    wait_idle(1, 300);
    btn2 = 1'b0;
    repeat (3) @(negedge clk);

    // Duck on the ground blocks a jump
    duck = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    check("duck_no_jump_airborne", 32'(air0), 32'd0);
    check("duck_ducking", 32'(duck0), 32'd1);
    check("duck_dinoY", 32'(dinoY0), 32'd181);
    duck = 1'b0;
    #1 check("unduck_ducking", 32'(duck0), 32'd0);
    repeat (3) @(negedge clk);

    // Fast-fall with duck held from the apex
    push_seq(0, duck_seq);
    button = 1'b1;
    wait_y0(126, 300);
    duck = 1'b1;
    wait_idle(0, 300);
    check("fastfall_landed_ducking", 32'(duck0), 32'd1);
    duck   = 1'b0;
    button = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-rise, then a clean jump
    push_seq(0, full_seq);
    button = 1'b1;
    wait_y0(154, 300);
    #2 nRst = 1'b0;
    sb0.delete();
    #1;
    check("midrst_dinoY", 32'(dinoY0), 32'd181);
    check("midrst_airborne", 32'(air0), 32'd0);
    check("midrst_land_pulse", 32'(land0), 32'd0);
    repeat (2) @(negedge clk);
    nRst   = 1'b1;
    button = 1'b0;
    repeat (2) @(negedge clk);
    push_seq(0, full_seq);
    button = 1'b1;
    @(negedge clk);
    check("postrst_airborne", 32'(air0), 32'd1);
    wait_idle(0, 300);
    button = 1'b0;
    repeat (5) @(negedge clk);

    check("final_sb1_empty", 32'(sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
